// File: rtl/axis_1553_encoder.sv
// rtl/axis_1553_encoder.sv - AXI-Stream word to MIL-STD-1553 Manchester II bus encoder
module axis_1553_encoder #(
  parameter int CLOCK_SPEED = 100000000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [15:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  tx_diff,
  output logic        tx_en
);

  localparam int H  = CLOCK_SPEED / 2000000;
  localparam int CW = $clog2(3 * H);
  localparam logic [CW-1:0] SYNC_LAST = CW'(3 * H - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] half_cnt_q, half_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          phase_q, phase_d;
  logic [15:0]   data_q, data_d;
  logic          cmd_q, cmd_d;
  logic          live_q, live_d;
  logic          half_end;
  logic          last_clk;
  logic          accept;
  logic          sym;
  logic          unused_tuser;

  assign unused_tuser = ^s_axis_tuser[7:1];

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      data_q     <= '0;
      cmd_q      <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      data_q     <= data_d;
      cmd_q      <= cmd_d;
      live_q     <= live_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    data_d     = data_q;
    cmd_d      = cmd_q;
    live_d     = 1'b1;
    tx_en      = 1'b0;
    tx_diff    = 2'b00;

    // A sync half lasts 3H clocks, a Manchester half-bit lasts H clocks.
    half_end = (state_q == SYNC) ? (half_cnt_q == SYNC_LAST) : (half_cnt_q == HALF_LAST);
    last_clk = (state_q == PARITY) && phase_q && half_end;
    // live_q keeps tready low until the first edge after reset releases.
    s_axis_tready = ((state_q == IDLE) && live_q) || last_clk;
    accept = s_axis_tready && s_axis_tvalid;

    case (state_q)
      SYNC:    sym = cmd_q;
      DATA:    sym = data_q[4'd15 - bit_cnt_q];
      PARITY:  sym = ~^data_q;
      default: sym = 1'b0;
    endcase

    // Symbol value drives the first half; phase_q inverts it for the second.
    if (state_q != IDLE) begin
      tx_en      = 1'b1;
      tx_diff    = (sym ^ phase_q) ? 2'b10 : 2'b01;
      half_cnt_d = half_cnt_q + 1'b1;
      if (half_end) begin
        half_cnt_d = '0;
        phase_d    = ~phase_q;
        if (phase_q) begin
          case (state_q)
            SYNC: state_d = DATA;
            DATA: begin
              if (bit_cnt_q == 4'd15) begin
                state_d   = PARITY;
                bit_cnt_d = '0;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end

    if (accept) begin
      data_d     = s_axis_tdata;
      cmd_d      = s_axis_tuser[0];
      state_d    = SYNC;
      half_cnt_d = '0;
      bit_cnt_d  = '0;
      phase_d    = 1'b0;
    end
  end

endmodule
